vector_reg_file_mw: RTL and testbench

//  Next-generation vector register file for the vector datapath: NREG registers of V lanes x D bits,
//  two combinational read ports, one write port with per-lane write mask, and a multi-cycle
//  "vclear" sweep engine that zeroes the file one register per cycle.

---
 rtl/vector_reg_file_mw_pkg.sv | 29 ++
 rtl/vector_reg_file_mw_if.sv | 31 +++
 rtl/vector_reg_file_mw_clear_seq.sv | 60 ++++++
 rtl/vector_reg_file_mw.sv | 71 +++++++
 tb/tb_vector_reg_file_mw.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/vector_reg_file_mw_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vrf_pkg : shared types and lane-merge helper for vector_reg_file_mw  (rev 1.0)
// ---------------------------------------------------------------------------
package vrf_pkg;

  localparam int VRF_S = 3;
  localparam int VRF_D = 8;
  localparam int VRF_V = 4;

  typedef logic [VRF_D-1:0] lane_t;
  typedef lane_t [VRF_V-1:0] vec_t;
  typedef logic [VRF_V-1:0] mask_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } vrf_state_e;

  function automatic vec_t merge_lanes(vec_t old_v, vec_t new_v, mask_t mask);
    vec_t r;
    for (int i = 0; i < VRF_V; i++) begin
      r[i] = mask[i] ? new_v[i] : old_v[i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_reg_file_mw_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vector_reg_file_mw_if : read/write/clear port bundle of the vector RF  (rev 1.0)
// ---------------------------------------------------------------------------
interface vector_reg_file_mw_if
  import vrf_pkg::*;
#(
  parameter int S = VRF_S
);
  logic         we3;
  logic [S-1:0] wa3;
  mask_t        wmask;
  vec_t         wd3;
  logic [S-1:0] ra1;
  logic [S-1:0] ra2;
  vec_t         rd1;
  vec_t         rd2;
  logic         clr_req;
  logic         busy;

  modport master (
    output we3, wa3, wmask, wd3, ra1, ra2, clr_req,
    input  rd1, rd2, busy
  );

  modport slave (
    input  we3, wa3, wmask, wd3, ra1, ra2, clr_req,
    output rd1, rd2, busy
  );
endinterface
`default_nettype wire

// File: rtl/vector_reg_file_mw_clear_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vrf_clear_seq : vclear sweep FSM, one register index per cycle from 1 up  (rev 1.0)
// ---------------------------------------------------------------------------
module vrf_clear_seq
  import vrf_pkg::*;
#(
  parameter int S = VRF_S
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [S-1:0]      clr_addr
);

  localparam logic [S-1:0] LAST = '1;

  vrf_state_e   state;
  logic [S-1:0] cnt;

  // Terminal compare precedes the increment, so cnt never wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= SWEEP;
            cnt   <= S'(1);
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + S'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule
`default_nettype wire

// File: rtl/vector_reg_file_mw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vector_reg_file_mw : 2R/1W masked vector register file with vclear sweep  (rev 1.0)
// Optional macro WRITE_BYPASS_EN: same-cycle write-to-read forwarding.
// ---------------------------------------------------------------------------
module vector_reg_file_mw
  import vrf_pkg::*;
#(
  parameter int S = VRF_S,
  parameter int D = VRF_D,
  parameter int V = VRF_V
) (
  input  wire logic clk,
  input  wire logic rst_n,
  vector_reg_file_mw_if.slave bus
);

  localparam int NREG = 2 ** S;

  // Lane geometry must match vec_t from the package; D/V shape the storage row.
  typedef logic [V-1:0][D-1:0] row_t;

  row_t         regs [NREG];
  logic         busy;
  logic         clr_we;
  logic [S-1:0] clr_addr;
  logic         wr_acc;

  vrf_clear_seq #(.S(S)) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;
  assign wr_acc   = bus.we3 && !busy && (bus.wa3 != '0);

  // Writes and sweep clears never coincide: writes are only accepted while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        regs[bus.wa3] <= merge_lanes(regs[bus.wa3], bus.wd3, bus.wmask);
      end
      if (clr_we) begin
        regs[clr_addr] <= '0;
      end
    end
  end

  always_comb begin
    bus.rd1 = (bus.ra1 == '0) ? '0 : regs[bus.ra1];
    bus.rd2 = (bus.ra2 == '0) ? '0 : regs[bus.ra2];
`ifdef WRITE_BYPASS_EN
    if (wr_acc && (bus.wa3 == bus.ra1)) begin
      bus.rd1 = merge_lanes(regs[bus.ra1], bus.wd3, bus.wmask);
    end
    if (wr_acc && (bus.wa3 == bus.ra2)) begin
      bus.rd2 = merge_lanes(regs[bus.ra2], bus.wd3, bus.wmask);
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_reg_file_mw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vector_reg_file_mw : directed self-checking bench for vector_reg_file_mw  (rev 1.0)
// ---------------------------------------------------------------------------
module tb_vector_reg_file_mw;
  import vrf_pkg::*;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  vector_reg_file_mw_if #(.S(3)) bus ();

  vector_reg_file_mw #(.S(3), .D(8), .V(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.we3   = 1'b1;
    bus.wa3   = a;
    bus.wd3   = d;
    bus.wmask = m;
    tick();
    bus.we3   = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n       = 1'b1;
    bus.we3     = 1'b0;
    bus.wa3     = '0;
    bus.wmask   = '0;
    bus.wd3     = '0;
    bus.ra1     = '0;
    bus.ra2     = '0;
    bus.clr_req = 1'b0;

    // Reset asserted asynchronously mid-cycle
    #2 rst_n = 1'b0;
    tick();
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus.ra1 = 3'(a);
      bus.ra2 = 3'(7 - a);
      #1;
      chk("reset_rd1", bus.rd1, 32'h0);
      chk("reset_rd2", bus.rd2, 32'h0);
    end
    #2 rst_n = 1'b1;
    tick();
    bus.ra1 = 3'd5;
    #1 chk("post_reset_rd1", bus.rd1, 32'h0);

    // Masked write: lanes 0 and 2 only
    write(3'd3, 32'hAABBCCDD, 4'b0101);
    bus.ra1 = 3'd3;
    #1 chk("masked_write", bus.rd1, 32'h00BB00DD);
    write(3'd3, 32'h11223344, 4'b1000);
    #1 chk("masked_write_hi", bus.rd1, 32'h11BB00DD);
    write(3'd3, 32'hFFFFFFFF, 4'b0000);
    #1 chk("mask_zero_noop", bus.rd1, 32'h11BB00DD);

    // Register 0 is hardwired to zero
    write(3'd0, 32'hFFFFFFFF, 4'hF);
    bus.ra1 = 3'd0;
    bus.ra2 = 3'd0;
    #1 chk("reg0_rd1", bus.rd1, 32'h0);
    chk("reg0_rd2", bus.rd2, 32'h0);
    tick();
    chk("reg0_later", bus.rd1, 32'h0);

    // Write-to-read in the same cycle
    write(3'd2, 32'h33333333, 4'hF);
    bus.ra1   = 3'd2;
    bus.ra2   = 3'd2;
    bus.we3   = 1'b1;
    bus.wa3   = 3'd2;
    bus.wd3   = 32'h11111111;
    bus.wmask = 4'hF;
    #1;
`ifdef WRITE_BYPASS_EN
    chk("bypass_full", bus.rd1, 32'h11111111);
`else
    chk("bypass_full", bus.rd1, 32'h33333333);
`endif
    tick();
    bus.we3 = 1'b0;
    #1 chk("write_visible", bus.rd1, 32'h11111111);
    bus.we3   = 1'b1;
    bus.wd3   = 32'hEEEEEEEE;
    bus.wmask = 4'b0011;
    #1;
`ifdef WRITE_BYPASS_EN
    chk("bypass_part", bus.rd2, 32'h1111EEEE);
`else
    chk("bypass_part", bus.rd2, 32'h11111111);
`endif
    tick();
    bus.we3 = 1'b0;
    #1 chk("part_visible", bus.rd2, 32'h1111EEEE);

    // Clear sweep
    for (int a = 1; a < 8; a++) write(3'(a), 32'h5A5A5A5A, 4'hF);
    bus.ra1 = 3'd3;
    #1 chk("fill_reg3", bus.rd1, 32'h5A5A5A5A);
    bus.clr_req = 1'b1;
    bus.we3     = 1'b1;
    bus.wa3     = 3'd7;
    bus.wd3     = 32'h77777777;
    bus.wmask   = 4'hF;
    #1 chk("busy_before_sweep", {31'd0, bus.busy}, 32'd0);
    tick();
    bus.clr_req = 1'b0;
    bus.we3     = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) begin
        bus.clr_req = 1'b1;
        bus.we3     = 1'b1;
        bus.wa3     = 3'd1;
        bus.wd3     = 32'hFFFFFFFF;
      end
      bus.ra1 = 3'(c);
      bus.ra2 = 3'(c - 1);
      #1;
      chk("sweep_busy", {31'd0, bus.busy}, 32'd1);
      chk("sweep_pending", bus.rd1, (c == 7) ? 32'h77777777 : 32'h5A5A5A5A);
      chk("sweep_cleared", bus.rd2, 32'h0);
      tick();
      bus.clr_req = 1'b0;
      bus.we3     = 1'b0;
    end
    chk("sweep_done_busy", {31'd0, bus.busy}, 32'd0);
    for (int a = 1; a < 8; a++) begin
      bus.ra1 = 3'(a);
      #1 chk("sweep_all_zero", bus.rd1, 32'h0);
    end
    tick();
    chk("no_restart", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of a sweep
    for (int a = 1; a < 8; a++) write(3'(a), 32'h5A5A5A5A, 4'hF);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    tick();
    tick();
    chk("mid_sweep_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    for (int a = 1; a < 8; a++) begin
      bus.ra1 = 3'(a);
      #0.1 chk("abort_zero", bus.rd1, 32'h0);
    end
    #1 rst_n = 1'b1;
    tick();
    write(3'd4, 32'h12345678, 4'hF);
    bus.ra1 = 3'd4;
    #1 chk("write_after_reset", bus.rd1, 32'h12345678);
    chk("idle_after_reset", {31'd0, bus.busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
